// File: rtl/smi_frame_arbiter_n_if.sv
// rtl/smi_frame_arbiter_n_if.sv - SMI input/output bundle for the N-port frame arbiter
interface smi_frame_arbiter_n_if #(
    parameter int FlitWidth    = 2,
    parameter int NumPorts     = 4,
    parameter int PortIdxWidth = 2
);
    logic [NumPorts-1:0]            smiInReady;
    logic [NumPorts*8-1:0]          smiInEofc;
    logic [NumPorts*FlitWidth*8-1:0] smiInData;
    logic [NumPorts-1:0]            smiInStop;
    logic [NumPorts-1:0]            portEnable;
    logic                           smiOutReady;
    logic [7:0]                     smiOutEofc;
    logic [FlitWidth*8-1:0]         smiOutData;
    logic [PortIdxWidth-1:0]        smiOutPort;
    logic                           smiOutStop;

    modport master (
        output smiInReady, smiInEofc, smiInData, portEnable, smiOutStop,
        input  smiInStop, smiOutReady, smiOutEofc, smiOutData, smiOutPort
    );

    modport slave (
        input  smiInReady, smiInEofc, smiInData, portEnable, smiOutStop,
        output smiInStop, smiOutReady, smiOutEofc, smiOutData, smiOutPort
    );
endinterface

// File: rtl/smi_frame_arbiter_n.sv
// rtl/smi_frame_arbiter_n.sv - N-input SMI frame arbiter, round-robin or fixed priority
module smi_frame_arbiter_n #(
    parameter int FlitWidth    = 2,
    parameter int NumPorts     = 4,
    parameter int PortIdxWidth = 2,
    parameter int ArbMode      = 0,
    parameter int EofcMask     = 2*FlitWidth-1
) (
    input  logic               clk,
    input  logic               srst,
    smi_frame_arbiter_n_if.slave smi
);
    localparam int DataWidth = FlitWidth*8;

    typedef enum logic {Idle, Xfer} arbState_t;

    arbState_t               state;
    logic [PortIdxWidth-1:0] grant;
    logic [PortIdxWidth-1:0] lastGrant;

    logic [NumPorts-1:0]  readyQ;
    logic [NumPorts-1:0]  lastQ;
    logic [7:0]           eofcQ [NumPorts];
    logic [DataWidth-1:0] dataQ [NumPorts];
    logic [NumPorts-1:0]  halt;
    logic [NumPorts-1:0]  grantHot;

    logic bufStop;

    always_comb begin
        grantHot = '0;
        for (int i = 0; i < NumPorts; i++) begin
            grantHot[i] = (state == Xfer) && (grant == PortIdxWidth'(i));
        end
        halt = ~grantHot | {NumPorts{bufStop}};
    end

    assign smi.smiInStop = readyQ & halt;

    // Input slices: the last flag is taken from the raw eofc before masking.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumPorts; i++) begin
            if (srst) begin
                readyQ[i] <= 1'b0;
                lastQ[i]  <= 1'b0;
            end else if (!(readyQ[i] && halt[i])) begin
                readyQ[i] <= smi.smiInReady[i];
                lastQ[i]  <= (smi.smiInEofc[8*i +: 8] != 8'd0);
            end
            if (!(readyQ[i] && halt[i])) begin
                eofcQ[i] <= smi.smiInEofc[8*i +: 8];
                dataQ[i] <= smi.smiInData[DataWidth*i +: DataWidth];
            end
        end
    end

    logic                 selReady;
    logic                 selLast;
    logic [7:0]           selEofc;
    logic [DataWidth-1:0] selData;

    always_comb begin
        selReady = 1'b0;
        selLast  = 1'b0;
        selEofc  = '0;
        selData  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (grant == PortIdxWidth'(i)) begin
                selReady = readyQ[i];
                selLast  = lastQ[i];
                selEofc  = eofcQ[i];
                selData  = dataQ[i];
            end
        end
    end

    logic push;
    logic frameEnd;
    assign push     = (state == Xfer) && selReady && !bufStop;
    assign frameEnd = push && selLast;

    // At a frame switch the finishing port competes only with the flit it is
    // loading this cycle, never with the last flit that is leaving.
    logic [NumPorts-1:0]     req;
    logic [PortIdxWidth-1:0] base;
    logic [PortIdxWidth-1:0] pick;
    logic                    anyReq;
    int                      rank;
    int                      bestRank;

    always_comb begin
        if (state == Xfer) begin
            req  = ((readyQ & ~grantHot) | (grantHot & smi.smiInReady)) & smi.portEnable;
            base = grant;
        end else begin
            req  = readyQ & smi.portEnable;
            base = lastGrant;
        end
        anyReq   = |req;
        pick     = '0;
        rank     = 0;
        bestRank = NumPorts;
        if (ArbMode == 1) begin
            for (int j = NumPorts-1; j >= 0; j--) begin
                if (req[j]) pick = PortIdxWidth'(j);
            end
        end else begin
            for (int j = 0; j < NumPorts; j++) begin
                rank = (j - int'(base) - 1 + 2*NumPorts) % NumPorts;
                if (req[j] && rank < bestRank) begin
                    bestRank = rank;
                    pick     = PortIdxWidth'(j);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= Idle;
            grant     <= '0;
            lastGrant <= PortIdxWidth'(NumPorts-1);
        end else begin
            case (state)
                Idle: begin
                    if (anyReq) begin
                        state <= Xfer;
                        grant <= pick;
                    end
                end
                Xfer: begin
                    if (frameEnd) begin
                        lastGrant <= grant;
                        if (anyReq) grant <= pick;
                        else        state <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    // Two-entry output buffer: entry 0 drives the outputs, entry 1 is the skid slot.
    logic                    v0, v1;
    logic [PortIdxWidth-1:0] p0, p1;
    logic [7:0]              e0, e1;
    logic [DataWidth-1:0]    d0, d1;
    logic                    pop;
    logic [7:0]              inEofc;

    assign bufStop = v1;
    assign pop     = v0 && !smi.smiOutStop;
    assign inEofc  = selEofc & 8'(EofcMask);

    always_ff @(posedge clk) begin
        if (srst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (v1) begin
            if (pop) begin
                v1 <= 1'b0;
                p0 <= p1;
                e0 <= e1;
                d0 <= d1;
            end
        end else if (v0) begin
            if (push && pop) begin
                p0 <= grant;
                e0 <= inEofc;
                d0 <= selData;
            end else if (push) begin
                v1 <= 1'b1;
                p1 <= grant;
                e1 <= inEofc;
                d1 <= selData;
            end else if (pop) begin
                v0 <= 1'b0;
            end
        end else if (push) begin
            v0 <= 1'b1;
            p0 <= grant;
            e0 <= inEofc;
            d0 <= selData;
        end
    end

    assign smi.smiOutReady = v0;
    assign smi.smiOutPort  = p0;
    assign smi.smiOutEofc  = e0;
    assign smi.smiOutData  = d0;
endmodule

// File: tb/tb_smi_frame_arbiter_n.sv
// tb/tb_smi_frame_arbiter_n.sv - directed bench for the N-port SMI frame arbiter
module tb_smi_frame_arbiter_n;
    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    smi_frame_arbiter_n_if #(.FlitWidth(2), .NumPorts(4), .PortIdxWidth(2)) ifA ();
    smi_frame_arbiter_n_if #(.FlitWidth(2), .NumPorts(4), .PortIdxWidth(2)) ifB ();

    smi_frame_arbiter_n #(.FlitWidth(2), .NumPorts(4), .PortIdxWidth(2), .ArbMode(0)) dutA (
        .clk(clk), .srst(srst), .smi(ifA)
    );
    smi_frame_arbiter_n #(.FlitWidth(2), .NumPorts(4), .PortIdxWidth(2), .ArbMode(1)) dutB (
        .clk(clk), .srst(srst), .smi(ifB)
    );

    // Source queues per instance/port: {eofc, data}
    logic [23:0] srcMem [2][4][64];
    int srcLen [2][4];
    int srcPos [2][4];
    int seqCnt [2][4];

    int nChk = 0;
    int nBad = 0;

    // Output logs: {port[3:0], eofc, data}
    logic [27:0] logA [256];
    logic [27:0] logB [256];
    int cycA [256];
    int cntA = 0;
    int cntB = 0;

    always @(negedge clk) begin
        if (ifA.smiOutReady && !ifA.smiOutStop) begin
            logA[cntA % 256] <= {2'b00, ifA.smiOutPort, ifA.smiOutEofc, ifA.smiOutData};
            cycA[cntA % 256] <= cyc;
            cntA <= cntA + 1;
        end
        if (ifB.smiOutReady && !ifB.smiOutStop) begin
            logB[cntB % 256] <= {2'b00, ifB.smiOutPort, ifB.smiOutEofc, ifB.smiOutData};
            cntB <= cntB + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic driveSrc();
        for (int p = 0; p < 4; p++) begin
            logic        ra, rb;
            logic [23:0] fa, fb;
            ra = srcPos[0][p] < srcLen[0][p];
            rb = srcPos[1][p] < srcLen[1][p];
            fa = ra ? srcMem[0][p][srcPos[0][p] % 64] : 24'h0;
            fb = rb ? srcMem[1][p][srcPos[1][p] % 64] : 24'h0;
            ifA.smiInReady[p]         = ra;
            ifA.smiInEofc[p*8 +: 8]   = fa[23:16];
            ifA.smiInData[p*16 +: 16] = fa[15:0];
            ifB.smiInReady[p]         = rb;
            ifB.smiInEofc[p*8 +: 8]   = fb[23:16];
            ifB.smiInData[p*16 +: 16] = fb[15:0];
        end
    endtask

    // Advance one cycle; sources step past flits accepted at this edge.
    task automatic tick();
        logic acc [2][4];
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            acc[0][p] = ifA.smiInReady[p] && !ifA.smiInStop[p];
            acc[1][p] = ifB.smiInReady[p] && !ifB.smiInStop[p];
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (acc[0][p]) srcPos[0][p]++;
            if (acc[1][p]) srcPos[1][p]++;
        end
        driveSrc();
        #1;
    endtask

    task automatic clearSrc();
        for (int n = 0; n < 2; n++) begin
            for (int p = 0; p < 4; p++) begin
                srcLen[n][p] = 0;
                srcPos[n][p] = 0;
                seqCnt[n][p] = 0;
            end
        end
        driveSrc();
    endtask

    task automatic addFrame(input int inst, input int p, input int len, input logic [7:0] lastEofc);
        for (int i = 0; i < len; i++) begin
            srcMem[inst][p][srcLen[inst][p] % 64] =
                {(i == len-1) ? lastEofc : 8'h00, 4'(p), 12'(seqCnt[inst][p])};
            srcLen[inst][p]++;
            seqCnt[inst][p]++;
        end
    endtask

    task automatic resetAll();
        srst = 1'b1;
        ifA.smiOutStop = 1'b0;
        ifB.smiOutStop = 1'b0;
        ifA.portEnable = 4'hF;
        ifB.portEnable = 4'hF;
        tick();
        tick();
        clearSrc();
        srst = 1'b0;
    endtask

    task automatic waitCnt(input int inst, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (((inst == 0) ? cntA : cntB) >= n) break;
            tick();
        end
    endtask

    initial begin
        int b;
        int k;
        logic [27:0] e;
        logic [27:0] e2;

        ifA.smiOutStop = 1'b0;
        ifB.smiOutStop = 1'b0;
        ifA.portEnable = 4'hF;
        ifB.portEnable = 4'hF;
        clearSrc();
        resetAll();

        checkVal("rst_outReadyA", 32'(ifA.smiOutReady), 0);
        checkVal("rst_inStopA", 32'(ifA.smiInStop), 0);
        checkVal("rst_outReadyB", 32'(ifB.smiOutReady), 0);
        checkVal("rst_inStopB", 32'(ifB.smiInStop), 0);

        // Single 3-flit frame on port 2
        b = cntA;
        k = cyc;
        addFrame(0, 2, 3, 8'h02);
        driveSrc();
        waitCnt(0, b + 3, 20);
        checkVal("t1_count", 32'(cntA - b), 3);
        for (int i = 0; i < 3; i++) begin
            e = logA[b + i];
            checkVal($sformatf("t1_cyc%0d", i), 32'(cycA[b + i]), 32'(k + 3 + i));
            checkVal($sformatf("t1_port%0d", i), 32'(e[27:24]), 2);
            checkVal($sformatf("t1_eofc%0d", i), 32'(e[23:16]), (i == 2) ? 2 : 0);
            checkVal($sformatf("t1_data%0d", i), 32'(e[15:0]), 32'h2000 + 32'(i));
        end

        // Round-robin: four ports each stream four 2-flit frames
        resetAll();
        b = cntA;
        for (int p = 0; p < 4; p++)
            for (int f = 0; f < 4; f++) addFrame(0, p, 2, 8'h01);
        driveSrc();
        waitCnt(0, b + 32, 120);
        checkVal("t2_count", 32'(cntA - b), 32);
        for (int f = 0; f < 16; f++) begin
            e  = logA[b + 2*f];
            e2 = logA[b + 2*f + 1];
            checkVal($sformatf("t2_port%0d", f), 32'(e[27:24]), 32'(f % 4));
            checkVal($sformatf("t2_data%0d", f), 32'(e[15:0]), {16'h0, 4'(f % 4), 12'(2*(f/4))});
            checkVal($sformatf("t2_eofc%0d", f), 32'(e2[23:16]), 1);
        end
        checkVal("t2_noBubble", 32'(cycA[b + 31] - cycA[b]), 31);

        // Fixed priority: ports 0 and 3 both requesting
        resetAll();
        b = cntB;
        for (int f = 0; f < 6; f++) addFrame(1, 0, 2, 8'h01);
        for (int f = 0; f < 2; f++) addFrame(1, 3, 2, 8'h01);
        driveSrc();
        waitCnt(1, b + 4, 30);
        for (int i = 0; i < 5; i++) begin
            checkVal($sformatf("t3_stop3_%0d", i), 32'(ifB.smiInStop[3]), 1);
            tick();
        end
        waitCnt(1, b + 16, 80);
        checkVal("t3_count", 32'(cntB - b), 16);
        for (int i = 0; i < 16; i++) begin
            e = logB[b + i];
            checkVal($sformatf("t3_port%0d", i), 32'(e[27:24]), (i < 12) ? 0 : 3);
        end

        // Output backpressure for five cycles in the middle of a port-1 frame
        resetAll();
        b = cntA;
        addFrame(0, 1, 10, 8'h03);
        addFrame(0, 2, 2, 8'h01);
        driveSrc();
        waitCnt(0, b + 3, 20);
        ifA.smiOutStop = 1'b1;
        tick();
        tick();
        checkVal("t4_stop1", 32'(ifA.smiInStop[1]), 1);
        checkVal("t4_stop2", 32'(ifA.smiInStop[2]), 1);
        checkVal("t4_stop3", 32'(ifA.smiInStop[3]), 0);
        checkVal("t4_outReady", 32'(ifA.smiOutReady), 1);
        tick();
        tick();
        tick();
        ifA.smiOutStop = 1'b0;
        waitCnt(0, b + 12, 40);
        checkVal("t4_count", 32'(cntA - b), 12);
        for (int i = 0; i < 12; i++) begin
            e = logA[b + i];
            checkVal($sformatf("t4_data%0d", i), 32'(e[15:0]),
                     (i < 10) ? {16'h0, 4'd1, 12'(i)} : {16'h0, 4'd2, 12'(i - 10)});
        end

        // portEnable[1] dropped mid-frame; port 2 frame ends on a masked-zero eofc
        resetAll();
        b = cntA;
        addFrame(0, 1, 6, 8'h01);
        addFrame(0, 1, 2, 8'h01);
        addFrame(0, 2, 2, 8'h04);
        addFrame(0, 3, 2, 8'h01);
        driveSrc();
        waitCnt(0, b + 1, 20);
        ifA.portEnable[1] = 1'b0;
        waitCnt(0, b + 10, 40);
        checkVal("t5_count", 32'(cntA - b), 10);
        for (int i = 0; i < 10; i++) begin
            e = logA[b + i];
            checkVal($sformatf("t5_port%0d", i), 32'(e[27:24]), (i < 6) ? 1 : ((i < 8) ? 2 : 3));
        end
        e = logA[b + 7];
        checkVal("t5_maskedEofc", 32'(e[23:16]), 0);
        for (int i = 0; i < 10; i++) tick();
        checkVal("t5_heldCount", 32'(cntA - b), 10);
        checkVal("t5_stop1", 32'(ifA.smiInStop[1]), 1);
        ifA.portEnable[1] = 1'b1;
        waitCnt(0, b + 12, 30);
        checkVal("t5_reCount", 32'(cntA - b), 12);
        e = logA[b + 10];
        checkVal("t5_rePort", 32'(e[27:24]), 1);
        checkVal("t5_reData", 32'(e[15:0]), 32'h1006);

        // Reset in the middle of a port-3 frame
        resetAll();
        b = cntA;
        addFrame(0, 3, 10, 8'h01);
        driveSrc();
        waitCnt(0, b + 2, 20);
        srst = 1'b1;
        tick();
        clearSrc();
        srst = 1'b0;
        checkVal("t6_outReady", 32'(ifA.smiOutReady), 0);
        checkVal("t6_inStop", 32'(ifA.smiInStop), 0);
        b = cntA;
        addFrame(0, 2, 2, 8'h01);
        addFrame(0, 1, 2, 8'h01);
        driveSrc();
        waitCnt(0, b + 4, 30);
        checkVal("t6_count", 32'(cntA - b), 4);
        e  = logA[b];
        e2 = logA[b + 2];
        checkVal("t6_firstPort", 32'(e[27:24]), 1);
        checkVal("t6_secondPort", 32'(e2[27:24]), 2);

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end
endmodule
